// File: rtl/layer0_input_framer.sv
// Packs a stream of quantized features into one frame word for the layer0 neuron array.
// Optional saturating framing-error counter enabled by defining FRAMER_ERRCNT_EN.
module layer0_input_framer #(
  parameter int FEAT_BITS = 2,
  parameter int NUM_FEAT  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NUM_FEAT*FEAT_BITS-1:0] m_data,
  output logic                          m_err
`ifdef FRAMER_ERRCNT_EN
  ,
  output logic [7:0]                    err_count
`endif
);

  localparam int FRAME_W = NUM_FEAT * FEAT_BITS;
  localparam int IDX_W   = $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {FILL, HOLD, RESYNC} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [FRAME_W-1:0] r_asm, r_mdata, w_frame;
  logic               r_mvalid, r_err;
  logic               w_accept, w_wr, w_load_new, w_load_held, w_err_nxt;

  assign s_ready  = (r_state != HOLD);
  assign w_accept = s_valid && s_ready;
  assign m_valid  = r_mvalid;
  assign m_data   = r_mdata;
  assign m_err    = r_err;

  // Assembly buffer with the current beat merged in, so a completing frame can load directly.
  always_comb begin
    w_frame = r_asm;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (r_idx == IDX_W'(k)) w_frame[k*FEAT_BITS +: FEAT_BITS] = s_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr        = 1'b0;
    w_load_new  = 1'b0;
    w_load_held = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_wr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (!s_last) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = RESYNC;
            end else if (!r_mvalid || m_ready) begin
              w_load_new = 1'b1;
            end else begin
              w_state_nxt = HOLD;
            end
          end else if (s_last) begin
            w_err_nxt = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        // Output register frees up this cycle; the held frame replaces it immediately.
        if (r_mvalid && m_ready) begin
          w_load_held = 1'b1;
          w_state_nxt = FILL;
        end
      end
      RESYNC: begin
        if (w_accept && s_last) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mvalid <= 1'b0;
      r_err    <= 1'b0;
      r_mdata  <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (w_load_new) begin
        r_mdata  <= w_frame;
        r_mvalid <= 1'b1;
      end else if (w_load_held) begin
        r_mdata  <= r_asm;
        r_mvalid <= 1'b1;
      end else if (m_ready) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_asm <= w_frame;
  end

`ifdef FRAMER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_layer0_input_framer.sv
// Bench for layer0_input_framer (NUM_FEAT=4, FEAT_BITS=2) against a frame-level queue model.
module tb_layer0_input_framer;
  localparam int NF = 4;
  localparam int FB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FB-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [NF*FB-1:0] m_data;
  logic          m_err;
`ifdef FRAMER_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  layer0_input_framer #(.FEAT_BITS(FB), .NUM_FEAT(NF)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
`ifdef FRAMER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model: completed frames not yet taken downstream, beats of the frame in progress.
  logic [NF*FB-1:0] mq[$];
  logic [FB-1:0]    cur[$];
  bit               resync;
  bit               exp_err;
  int               exp_cnt;

  task automatic model_clear();
    mq.delete();
    cur.delete();
    resync  = 0;
    exp_err = 0;
    exp_cnt = 0;
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model, return at the next negedge.
  task automatic cycle(input bit v, input logic [FB-1:0] d, input bit l, input bit mr);
    bit rdy, hs;
    logic [NF*FB-1:0] f;
    s_valid = v; s_data = d; s_last = l; m_ready = mr;
    rdy = (mq.size() < 2);
    hs  = (mq.size() > 0) && mr;
    exp_err = 0;
    if (hs) void'(mq.pop_front());
    if (v && rdy) begin
      if (resync) begin
        if (l) resync = 0;
      end else begin
        cur.push_back(d);
        if (l) begin
          if (cur.size() == NF) begin
            f = '0;
            for (int k = 0; k < NF; k++) f[k*FB +: FB] = cur[k];
            mq.push_back(f);
          end else begin
            exp_err = 1;
          end
          cur.delete();
        end else if (cur.size() == NF) begin
          exp_err = 1;
          resync  = 1;
          cur.delete();
        end
      end
    end
    if (exp_err && exp_cnt < 255) exp_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [NF*FB-1:0] f, input bit mr);
    for (int k = 0; k < NF; k++) cycle(1'b1, f[k*FB +: FB], (k == NF-1), mr);
  endtask

  // Reset with a simultaneous handshake and frame-completing beat that must be ignored.
  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 2'd3; s_last = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL reset_merr got=%b exp=0", m_err); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL reset_mdata got=%h exp=00", m_data); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_sready got=%b exp=1", s_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1, 2'd1, 0, 1);
    cycle(1, 2'd2, 0, 1);
    cycle(1, 2'd3, 0, 1);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_early_mvalid got=%b exp=0", m_valid); end
    cycle(1, 2'd0, 1, 1);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_mvalid got=%b exp=1", m_valid); end
    total++; if (m_data !== 8'b00111001) begin bad++; $display("FAIL basic_mdata got=%b exp=00111001", m_data); end
    cycle(0, 2'd0, 0, 1);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_clear got=%b exp=0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] fa, fb;
    do_reset();
    fa = 8'($urandom); fb = 8'($urandom);
    send_frame(fa, 0);
    total++; if (m_data !== fa || m_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/%h", m_valid, m_data, fa); end
    send_frame(fb, 0);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_sready got=%b exp=0", s_ready); end
    total++; if (m_data !== fa) begin bad++; $display("FAIL bp_stable got=%h exp=%h", m_data, fa); end
    cycle(1, 2'd2, 1, 0);
    total++; if (m_data !== fa || s_ready !== 1'b0) begin bad++; $display("FAIL bp_still_hold got=%h/%b exp=%h/0", m_data, s_ready, fa); end
    cycle(0, 2'd0, 0, 1);
    total++; if (m_data !== fb || m_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%b/%h exp=1/%h", m_valid, m_data, fb); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_release_sready got=%b exp=1", s_ready); end
    cycle(0, 2'd0, 0, 1);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", m_valid); end
  endtask

  task automatic test_short_frame();
    logic [7:0] f;
    do_reset();
    f = 8'($urandom);
    cycle(1, 2'd1, 0, 1);
    cycle(1, 2'd2, 1, 1);
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", m_err); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL short_mvalid got=%b exp=0", m_valid); end
    cycle(0, 2'd0, 0, 1);
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%b exp=0", m_err); end
    send_frame(f, 1);
    total++; if (m_valid !== 1'b1 || m_data !== f) begin bad++; $display("FAIL short_next got=%b/%h exp=1/%h", m_valid, m_data, f); end
  endtask

  task automatic test_long_frame();
    logic [7:0] f;
    do_reset();
    f = 8'($urandom);
    for (int k = 0; k < 4; k++) cycle(1, 2'(k), 0, 1);
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL long_err got=%b exp=1", m_err); end
    cycle(1, 2'd3, 1, 1);
    total++; if (m_err !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL long_drop got=%b/%b exp=0/0", m_err, m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL long_sready got=%b exp=1", s_ready); end
    send_frame(f, 1);
    total++; if (m_valid !== 1'b1 || m_data !== f) begin bad++; $display("FAIL long_next got=%b/%h exp=1/%h", m_valid, m_data, f); end
  endtask

  task automatic test_reset_in_hold();
    logic [7:0] f;
    do_reset();
    send_frame(8'($urandom), 0);
    send_frame(8'($urandom), 0);
    total++; if (s_ready !== 1'b0 || m_valid !== 1'b1) begin bad++; $display("FAIL rsth_pre got=%b/%b exp=0/1", s_ready, m_valid); end
    do_reset();
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL rsth_post got=%b/%b exp=0/1", m_valid, s_ready); end
    cycle(1, 2'd3, 0, 1);
    cycle(1, 2'd1, 0, 1);
    do_reset();
    f = 8'($urandom);
    send_frame(f, 1);
    total++; if (m_valid !== 1'b1 || m_data !== f) begin bad++; $display("FAIL rst_midframe got=%b/%h exp=1/%h", m_valid, m_data, f); end
  endtask

  task automatic test_random();
    bit v, l, mr;
    logic [FB-1:0] d;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      d  = 2'($urandom);
      if (resync) l = ($urandom_range(0, 2) == 0);
      else if (cur.size() == NF-1) l = ($urandom_range(0, 19) != 0);
      else l = ($urandom_range(0, 29) == 0);
      cycle(v, d, l, mr);
      total++; if (m_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_mvalid cyc=%0d got=%b exp=%b", i, m_valid, (mq.size() > 0)); end
      total++; if (s_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rnd_sready cyc=%0d got=%b exp=%b", i, s_ready, (mq.size() < 2)); end
      total++; if (m_err !== exp_err) begin bad++; $display("FAIL rnd_merr cyc=%0d got=%b exp=%b", i, m_err, exp_err); end
      if (mq.size() > 0) begin
        total++; if (m_data !== mq[0]) begin bad++; $display("FAIL rnd_mdata cyc=%0d got=%h exp=%h", i, m_data, mq[0]); end
      end
`ifdef FRAMER_ERRCNT_EN
      total++; if (err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL rnd_errcnt cyc=%0d got=%0d exp=%0d", i, err_count, exp_cnt); end
`endif
    end
  endtask

`ifdef FRAMER_ERRCNT_EN
  task automatic test_errcnt();
    do_reset();
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL errcnt_reset got=%0d exp=0", err_count); end
    for (int i = 0; i < 260; i++) begin
      cycle(1, 2'($urandom), 1, 1);
      if (i == 99) begin
        total++; if (err_count !== 8'd100) begin bad++; $display("FAIL errcnt_100 got=%0d exp=100", err_count); end
      end
    end
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL errcnt_sat got=%0d exp=255", err_count); end
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL errcnt_merr got=%b exp=1", m_err); end
  endtask
`endif

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_in_hold();
    test_random();
`ifdef FRAMER_ERRCNT_EN
    test_errcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer0_input_framer.md
LAYER0_INPUT_FRAMER -- requirements
Module: layer0_input_framer

Interface
REQ-001 The block SHALL have parameter FEAT_BITS, default 2: width of one quantized input feature.
REQ-002 The block SHALL have parameter NUM_FEAT, default 64: features per frame, range 2..256.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream feature beat valid.
REQ-006 s_ready  output  1  block accepts a beat this cycle.
REQ-007 s_data  input  FEAT_BITS  quantized feature value.
REQ-008 s_last  input  1  marks the final feature of a frame.
REQ-009 m_valid  output  1  packed frame available to the layer0 neuron array.
REQ-010 m_ready  input  1  downstream accepts the frame.
REQ-011 m_data  output  NUM_FEAT*FEAT_BITS  packed frame; feature k at bits [k*FEAT_BITS +: FEAT_BITS].
REQ-012 m_err  output  1  one-cycle pulse on a framing error.

Function
REQ-013 A beat SHALL be accepted only in a cycle where s_valid and s_ready are both 1.
REQ-014 A 0..NUM_FEAT-1 index counter SHALL place each accepted beat into the assembly buffer at its index, then increment.
REQ-015 State machine: FILL (accepting), HOLD (frame complete, output busy), RESYNC (discarding after error).
REQ-016 s_ready SHALL be 1 in FILL and RESYNC, and 0 in HOLD.
REQ-017 On accepting index NUM_FEAT-1 with s_last=1:
  - if m_valid=0 or m_ready=1 that cycle, load the completed frame into the output register (m_valid=1 next cycle, latency 1) and stay in FILL with index 0;
  - otherwise enter HOLD.
REQ-018 In HOLD, when m_valid=1 and m_ready=1, the output register SHALL load the held frame in that same cycle; the FSM then returns to FILL with index 0.
REQ-019 m_valid SHALL clear after a handshake unless a new frame loads in that same cycle; m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-020 s_last=1 on index < NUM_FEAT-1 SHALL discard the partial frame, pulse m_err, reset the index to 0, and stay in FILL.
REQ-021 Index NUM_FEAT-1 accepted with s_last=0 SHALL discard the frame, pulse m_err, and enter RESYNC.
REQ-022 In RESYNC, beats SHALL be accepted and dropped; the beat with s_last=1 returns the FSM to FILL with index 0, with no further m_err.
REQ-023 Unwritten assembly bits are don't-care; m_data SHALL only be valid while m_valid=1.

Reset
REQ-024 rst=1 SHALL force FILL, index 0, m_valid=0, m_err=0, and m_data=0, overriding any simultaneous handshake.
REQ-025 Reset mid-frame or in HOLD/RESYNC SHALL discard all buffered data; s_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 With FRAMER_ERRCNT_EN defined, the block SHALL add output err_count (8 bits), reset to 0, incremented on every m_err pulse and saturating at 255.
REQ-027 Without FRAMER_ERRCNT_EN defined, err_count and its counter SHALL NOT exist; all other behaviour is identical.

Verification (NUM_FEAT=4, FEAT_BITS=2 unless noted)
REQ-028 m_ready=1; beats 1,2,3,0 with s_last on the 4th -> m_valid one cycle later, m_data=8'b00111001.
REQ-029 m_ready=0; two complete frames -> second frame held, s_ready=0; m_ready=1 for one cycle -> frame 2 appears next cycle, s_ready=1.
REQ-030 s_last on the 2nd beat -> m_err pulses once, no m_valid; the next 4-beat frame is output correctly.
REQ-031 5-beat frame with s_last on the 5th -> m_err on beat 4, beat 5 dropped, the following frame is correct.
REQ-032 rst asserted while in HOLD with m_valid=1 -> next cycle m_valid=0, s_ready=1, index 0.
REQ-033 With FRAMER_ERRCNT_EN defined, 260 consecutive short frames -> err_count=255.
